// File: rtl/timestamp_keeper.sv
// Timestamp keeper: holds a running Unix-seconds count loaded from a host
// timestamp and advances it once per CLK_HZ clock cycles.
//
// Host updates are signalled by a change of ts_i[32]; either edge loads
// ts_i[31:0]. The first edge after reset only samples the toggle level so a
// static level is never mistaken for an update.
//
// Build option: define TIMESTAMP_SYNC_EN to pass ts_i through a two-flop
// synchronizer (adds two cycles of load latency). Without it, ts_i must be
// synchronous to clk_i.
module timestamp_keeper #(
    parameter int unsigned CLK_HZ = 50000000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [32:0] ts_i,
    output logic [32:0] time_o,
    output logic        tick_o,
    output logic        load_o
);

    // Prescale width: ceil(log2(CLK_HZ)), at least one bit.
    localparam int unsigned PW = (CLK_HZ < 2) ? 1 : $clog2(CLK_HZ);
    localparam logic [PW-1:0] PreMax = PW'(CLK_HZ - 1);

    // Host timestamp as seen by the load logic.
    logic [32:0] ts_eff;

`ifdef TIMESTAMP_SYNC_EN
    logic [32:0] ts_s1_q;
    logic [32:0] ts_s2_q;

    // Two-flop synchronizer for the asynchronous host timestamp.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ts_s1_q <= '0;
            ts_s2_q <= '0;
        end else begin
            ts_s1_q <= ts_i;
            ts_s2_q <= ts_s1_q;
        end
    end

    assign ts_eff = ts_s2_q;
`else
    assign ts_eff = ts_i;
`endif

    logic          armed_q,  armed_d;
    logic          toggle_q, toggle_d;
    logic [PW-1:0] pre_q,    pre_d;
    logic [31:0]   sec_q,    sec_d;
    logic          valid_q,  valid_d;
    logic          tick_q,   tick_d;
    logic          load_q,   load_d;
    logic          load_ev;
    logic          pre_wrap;

    // A toggle change only counts once the first post-reset sample is taken.
    assign load_ev  = armed_q && (ts_eff[32] != toggle_q);
    assign pre_wrap = (pre_q == PreMax);

    // Next-state: load has priority over the prescale wrap.
    always_comb begin
        armed_d  = 1'b1;
        toggle_d = ts_eff[32];
        pre_d    = pre_q;
        sec_d    = sec_q;
        valid_d  = valid_q;
        tick_d   = 1'b0;
        load_d   = 1'b0;

        if (load_ev) begin
            sec_d   = ts_eff[31:0];
            pre_d   = '0;
            valid_d = 1'b1;
            load_d  = 1'b1;
        end else if (valid_q) begin
            if (pre_wrap) begin
                pre_d  = '0;
                sec_d  = sec_q + 32'd1;
                tick_d = 1'b1;
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end
    end

    // State registers; reset discards everything including the armed flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            armed_q  <= 1'b0;
            toggle_q <= 1'b0;
            pre_q    <= '0;
            sec_q    <= '0;
            valid_q  <= 1'b0;
            tick_q   <= 1'b0;
            load_q   <= 1'b0;
        end else begin
            armed_q  <= armed_d;
            toggle_q <= toggle_d;
            pre_q    <= pre_d;
            sec_q    <= sec_d;
            valid_q  <= valid_d;
            tick_q   <= tick_d;
            load_q   <= load_d;
        end
    end

    assign time_o = {valid_q, sec_q};
    assign tick_o = tick_q;
    assign load_o = load_q;

endmodule

// File: doc/timestamp_keeper.md
TIMESTAMP_KEEPER -- requirements
Module: timestamp_keeper

Interface
REQ-001 Parameter CLK_HZ, default 50000000, clk_i cycles per second; legal range 2..2^32-1.
REQ-002 clk_i  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 ts_i  input  33  host timestamp; [31:0] Unix seconds, [32] toggles on each new host value.
REQ-005 time_o  output  33  running time to io_misc boot_time input; [31:0] seconds, [32] valid.
REQ-006 tick_o  output  1  one-cycle pulse on each counted second.
REQ-007 load_o  output  1  one-cycle pulse on each accepted host load.

Function
REQ-008 Internal state: armed flag, toggle_q (last seen ts_i[32]), prescale counter (ceil(log2(CLK_HZ)) bits), seconds (32 bits), valid flag.
REQ-009 The first clock edge after reset release shall set armed=1 and toggle_q=ts_i[32], with no load; this prevents a static toggle level from being taken as an update.
REQ-010 While armed, ts_i[32] != toggle_q on an edge is a load event; either transition direction counts.
REQ-011 On a load event: seconds<=ts_i[31:0], prescale<=0, valid<=1, toggle_q<=ts_i[32], load_o=1 for exactly that following cycle.
REQ-012 Load latency: toggle change sampled at edge N -> time_o and load_o updated from edge N (visible cycle N+1); no further pipeline.
REQ-013 While valid=0: prescale held at 0, seconds held, tick_o=0.
REQ-014 While valid=1 and no load: prescale increments each cycle.
REQ-015 When prescale==CLK_HZ-1: prescale<=0, seconds<=seconds+1, tick_o=1 for one cycle.
REQ-016 Seconds increment is modulo 2^32; 0xFFFFFFFF wraps to 0x00000000 with tick_o, valid stays 1.
REQ-017 Load and prescale wrap in the same cycle: load wins; seconds=ts_i[31:0], prescale=0, tick_o=0, load_o=1.
REQ-018 Loading a value equal to the current seconds still restarts prescale and pulses load_o.
REQ-019 time_o = {valid, seconds}, driven directly from registers (no combinational path from ts_i).
REQ-020 Once set, valid shall clear only on reset.

Reset
REQ-021 rst_i asserted asynchronously forces armed=0, toggle_q=0, prescale=0, seconds=0, valid=0, so time_o=33'h0, tick_o=0, load_o=0.
REQ-022 Reset mid-count or mid-load discards all state; after release, the block re-arms per REQ-009 and waits for the next toggle.

Configuration
REQ-023 Macro TIMESTAMP_SYNC_EN: when defined, ts_i passes through a two-flop synchronizer (reset to 0) before all logic; load latency becomes 3 edges; REQ-009 samples the synchronized toggle.
REQ-024 Without TIMESTAMP_SYNC_EN: ts_i is used directly; latency per REQ-012; ts_i must be synchronous to clk_i.

Verification (CLK_HZ=10)
REQ-025 Reset, ts_i=33'h1_0000_0000 static -> time_o=0 and valid=0 forever, no tick_o, no load_o.
REQ-026 After arm, toggle ts_i to {0,32'h6500_0000} -> next cycle time_o=33'h1_6500_0000, load_o=1; 10 cycles later seconds=32'h6500_0001 with tick_o=1.
REQ-027 Load 32'hFFFF_FFFF -> after 10 cycles time_o=33'h1_0000_0000, tick_o=1.
REQ-028 Toggle arriving on the cycle prescale==9 with ts=32'h100 -> seconds=32'h100, tick_o=0, load_o=1; next tick 10 cycles later, seconds=32'h101.
REQ-029 Assert rst_i asynchronously mid-count (between edges) -> time_o=0 immediately; a toggle on the first edge after release is not loaded.
REQ-030 With TIMESTAMP_SYNC_EN: toggle at edge N -> load_o=1 in cycle after edge N+2.
